icache_2way: RTL and testbench

ICACHE_2WAY -- requirements
Module: icache_2way

---
 rtl/icache_2way.sv | 179 +++++++++++++++++
 tb/tb_icache_2way.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with per-set LRU and a single
// outstanding line refill; flush requests arriving mid-refill are deferred to IDLE.
module icache_2way #(
  parameter int ADDR_W = 32,
  parameter int WORDS  = 4,
  parameter int SETS   = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                req,
  input  logic [ADDR_W-1:0]   address,
  input  logic                flush,
  output logic [31:0]         inst,
  output logic                rsp_valid,
  output logic                hit,
  output logic                busy,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ack,
  input  logic [32*WORDS-1:0] mem_data
);

  localparam int OFF  = $clog2(WORDS) + 2;
  localparam int IDX  = $clog2(SETS);
  localparam int TAG  = ADDR_W - OFF - IDX;
  localparam int LINE = 32 * WORDS;
  localparam int WSEL = OFF - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2,
    FILL   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [ADDR_W-1:0]   addr_r;
  logic                flush_pend_r;
  logic [1:0][SETS-1:0] valid_r;
  logic [SETS-1:0]     lru_r;
  logic [TAG-1:0]      tag_r  [2][SETS];
  logic [LINE-1:0]     data_r [2][SETS];
  logic [LINE-1:0]     fill_line_r;
  logic [31:0]         inst_r;
  logic                rsp_valid_r;
  logic                hit_r;
  logic                busy_r;
  logic                mem_req_r;
  logic [ADDR_W-1:0]   mem_addr_r;

  logic                flush_now_s;
  logic                accept_s;
  logic [IDX-1:0]      idx_s;
  logic [TAG-1:0]      tag_s;
  logic [WSEL-1:0]     word_s;
  logic                hit0_s;
  logic                hit1_s;
  logic                hit_way_s;
  logic                victim_s;
  logic [LINE-1:0]     hit_line_s;
  logic                addr_unused_s;

  assign idx_s         = addr_r[OFF+IDX-1:OFF];
  assign tag_s         = addr_r[ADDR_W-1:OFF+IDX];
  assign word_s        = addr_r[OFF-1:2];
  assign addr_unused_s = ^addr_r[1:0];

  // Way 0 wins if both ways ever match the same tag.
  assign hit0_s     = valid_r[0][idx_s] && (tag_r[0][idx_s] == tag_s);
  assign hit1_s     = valid_r[1][idx_s] && (tag_r[1][idx_s] == tag_s);
  assign hit_way_s  = hit0_s ? 1'b0 : 1'b1;
  assign hit_line_s = data_r[hit_way_s][idx_s];
  assign victim_s   = !valid_r[0][idx_s] ? 1'b0 :
                      !valid_r[1][idx_s] ? 1'b1 : lru_r[idx_s];

  assign inst      = inst_r;
  assign rsp_valid = rsp_valid_r;
  assign hit       = hit_r;
  assign busy      = busy_r;
  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // Next-state decode; a flush (new or deferred) blocks request acceptance.
  always_comb begin
    next_state_s = state_r;
    flush_now_s  = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush || flush_pend_r) begin
          flush_now_s = 1'b1;
        end else if (req) begin
          accept_s     = 1'b1;
          next_state_s = LOOKUP;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOOKUP: begin
        if (hit0_s || hit1_s) next_state_s = IDLE;
        else                  next_state_s = MISS;
      end
      MISS: begin
        if (mem_ack) next_state_s = FILL;
        else         next_state_s = MISS;
      end
      FILL:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Control, status and response registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      addr_r       <= '0;
      flush_pend_r <= 1'b0;
      valid_r      <= '0;
      lru_r        <= '0;
      fill_line_r  <= '0;
      inst_r       <= 32'd0;
      rsp_valid_r  <= 1'b0;
      hit_r        <= 1'b0;
      busy_r       <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= '0;
    end else begin
      busy_r      <= (next_state_s != IDLE);
      mem_req_r   <= (next_state_s == MISS);
      rsp_valid_r <= 1'b0;
      hit_r       <= 1'b0;
      if (accept_s) addr_r <= address;
      if (state_r == IDLE) flush_pend_r <= 1'b0;
      else if (flush)      flush_pend_r <= 1'b1;
      if (flush_now_s) begin
        valid_r <= '0;
        lru_r   <= '0;
      end
      case (state_r)
        LOOKUP: begin
          if (hit0_s || hit1_s) begin
            inst_r        <= hit_line_s[{word_s, 5'd0} +: 32];
            rsp_valid_r   <= 1'b1;
            hit_r         <= 1'b1;
            lru_r[idx_s]  <= ~hit_way_s;
          end else begin
            mem_addr_r <= {tag_s, idx_s, {OFF{1'b0}}};
          end
        end
        MISS: begin
          if (mem_ack) fill_line_r <= mem_data;
        end
        FILL: begin
          valid_r[victim_s][idx_s] <= 1'b1;
          lru_r[idx_s]             <= ~victim_s;
          inst_r                   <= fill_line_r[{word_s, 5'd0} +: 32];
          rsp_valid_r              <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Tag and data arrays; contents are don't-care until the valid bit is set.
  always_ff @(posedge Clk) begin
    if (state_r == FILL) begin
      tag_r[victim_s][idx_s]  <= tag_s;
      data_r[victim_s][idx_s] <= fill_line_r;
    end
  end

endmodule

// File: tb/tb_icache_2way.sv
// Directed bench for icache_2way: a line-level recency model predicts every
// cycle's outputs, and literal expectations pin the key scenarios.
module tb_icache_2way;

  logic         Clk;
  logic         Rst;
  logic         req;
  logic [31:0]  address;
  logic         flush;
  logic [31:0]  inst;
  logic         rsp_valid;
  logic         hit;
  logic         busy;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [127:0] mem_data;

  icache_2way #(.ADDR_W(32), .WORDS(4), .SETS(8)) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .address(address), .flush(flush),
    .inst(inst), .rsp_valid(rsp_valid), .hit(hit), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        exp_rsp, exp_hit, exp_busy, exp_mem_req;
  logic [31:0] exp_inst, exp_mem_addr;
  bit          chk_en;

  // Resident lines, oldest first; at most two per set.
  int unsigned  res_q[$];
  logic [127:0] line_data [int unsigned];

  function automatic int unsigned set_of(input int unsigned la);
    return (la >> 4) & 32'd7;
  endfunction

  function automatic bit model_resident(input int unsigned la);
    bit f = 1'b0;
    foreach (res_q[i]) if (res_q[i] == la) f = 1'b1;
    return f;
  endfunction

  function automatic void model_touch(input int unsigned la);
    int k = -1;
    foreach (res_q[i]) if (res_q[i] == la && k < 0) k = i;
    if (k >= 0) res_q.delete(k);
    res_q.push_back(la);
  endfunction

  function automatic void model_fill(input int unsigned la, input logic [127:0] line);
    int cnt = 0;
    int first = -1;
    foreach (res_q[i]) begin
      if (set_of(res_q[i]) == set_of(la)) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    if (cnt >= 2) res_q.delete(first);
    res_q.push_back(la);
    line_data[la] = line;
  endfunction

  function automatic void model_clear();
    res_q.delete();
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, ex, $time);
    end
  endtask

  // Per-cycle comparison against the model's expectations.
  always @(negedge Clk) begin
    if (chk_en) begin
      cmp("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      cmp("hit", 32'(hit), 32'(exp_hit));
      cmp("busy", 32'(busy), 32'(exp_busy));
      cmp("mem_req", 32'(mem_req), 32'(exp_mem_req));
      cmp("inst", inst, exp_inst);
      if (exp_mem_req) cmp("mem_addr", mem_addr, exp_mem_addr);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One fetch from IDLE to the cycle after its response.
  task automatic fetch(input logic [31:0] a, input logic [127:0] line, input int dly,
                       input bit fl, output bit got_hit, output logic [31:0] got_inst,
                       output logic [31:0] got_maddr);
    int unsigned  la;
    int unsigned  w;
    bit           m_hit;
    logic [127:0] tmp;
    la    = a & ~32'hF;
    w     = (a >> 2) & 32'd3;
    m_hit = model_resident(la);
    got_maddr = 32'd0;
    req = 1'b1;
    address = a;
    tick();
    req = 1'b0;
    exp_busy = 1'b1;
    exp_mem_req = 1'b0;
    tick();
    if (m_hit) begin
      tmp = line_data[la];
      exp_rsp = 1'b1;
      exp_hit = 1'b1;
      exp_busy = 1'b0;
      exp_inst = tmp[32*w +: 32];
      model_touch(la);
    end else begin
      exp_mem_req  = 1'b1;
      exp_mem_addr = la;
      got_maddr    = mem_addr;
      for (int i = 0; i < dly; i++) begin
        mem_data = ~line;
        if (fl && i == 0) flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      mem_ack = 1'b1;
      mem_data = line;
      tick();
      mem_ack = 1'b0;
      mem_data = 128'd0;
      exp_mem_req = 1'b0;
      tick();
      exp_rsp = 1'b1;
      exp_hit = 1'b0;
      exp_busy = 1'b0;
      exp_inst = line[32*w +: 32];
      model_fill(la, line);
    end
    got_hit  = hit;
    got_inst = inst;
    tick();
    exp_rsp = 1'b0;
    exp_hit = 1'b0;
    if (fl) model_clear();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          gh;
    logic [31:0] gi, ga;
    logic [31:0] ws [4];
    ws = '{32'h11, 32'h22, 32'h33, 32'h44};
    Rst = 1'b1; req = 1'b0; address = 32'd0; flush = 1'b0;
    mem_ack = 1'b0; mem_data = 128'd0;
    exp_rsp = 1'b0; exp_hit = 1'b0; exp_busy = 1'b0; exp_mem_req = 1'b0;
    exp_inst = 32'd0; exp_mem_addr = 32'd0; chk_en = 1'b0;
    #12;
    cmp("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    cmp("reset_busy", 32'(busy), 32'd0);
    cmp("reset_mem_req", 32'(mem_req), 32'd0);
    cmp("reset_inst", inst, 32'd0);
    cmp("reset_mem_addr", mem_addr, 32'd0);
    chk_en = 1'b1;
    tick();
    Rst = 1'b0;
    tick();

    // Cold miss then hit on the same line.
    fetch(32'h44, {32'hA3, 32'hA2, 32'hDEAD_BEEF, 32'hA0}, 2, 1'b0, gh, gi, ga);
    cmp("cold_mem_addr", ga, 32'h40);
    cmp("cold_hit", 32'(gh), 32'd0);
    cmp("cold_inst", gi, 32'hDEAD_BEEF);
    fetch(32'h44, 128'd0, 0, 1'b0, gh, gi, ga);
    cmp("rehit_hit", 32'(gh), 32'd1);
    cmp("rehit_inst", gi, 32'hDEAD_BEEF);

    // Three lines in set 4: 0x140 evicts 0x040.
    fetch(32'hC0, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 0, 1'b0, gh, gi, ga);
    fetch(32'h140, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1, 1'b0, gh, gi, ga);
    fetch(32'hC0, 128'd0, 0, 1'b0, gh, gi, ga);
    cmp("conflict_0c0_hit", 32'(gh), 32'd1);
    cmp("conflict_0c0_inst", gi, 32'hC0);
    fetch(32'h40, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 0, 1'b0, gh, gi, ga);
    cmp("conflict_040_hit", 32'(gh), 32'd0);
    cmp("conflict_040_addr", ga, 32'h40);

    // Word select within one line.
    fetch(32'h80, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 1'b0, gh, gi, ga);
    cmp("word0_fill_inst", gi, 32'h11);
    for (int k = 1; k < 4; k++) begin
      fetch(32'h80 + 32'(4 * k), 128'd0, 0, 1'b0, gh, gi, ga);
      cmp("word_hit", 32'(gh), 32'd1);
      cmp("word_inst", gi, ws[k]);
    end

    // Flush in IDLE.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_clear();
    fetch(32'h44, {32'h3, 32'h2, 32'hDEAD_BEEF, 32'h0}, 0, 1'b0, gh, gi, ga);
    cmp("flush_idle_hit", 32'(gh), 32'd0);
    cmp("flush_idle_addr", ga, 32'h40);

    // Flush together with req: flush wins.
    req = 1'b1; flush = 1'b1; address = 32'h44;
    tick();
    cmp("flush_wins_busy", 32'(busy), 32'd0);
    req = 1'b0; flush = 1'b0;
    model_clear();
    tick();
    fetch(32'h44, {32'h3, 32'h2, 32'h1, 32'h0}, 0, 1'b0, gh, gi, ga);
    cmp("flush_wins_miss", 32'(gh), 32'd0);

    // Flush raised during MISS: refill still responds, then the line is gone.
    fetch(32'hC4, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 2, 1'b1, gh, gi, ga);
    cmp("flush_miss_hit", 32'(gh), 32'd0);
    cmp("flush_miss_inst", gi, 32'hF1);
    fetch(32'hC4, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 1, 1'b0, gh, gi, ga);
    cmp("flush_miss_again", 32'(gh), 32'd0);

    // Asynchronous reset during a refill.
    req = 1'b1; address = 32'h200;
    tick();
    req = 1'b0; exp_busy = 1'b1;
    tick();
    exp_mem_req = 1'b1; exp_mem_addr = 32'h200;
    tick();
    #2;
    Rst = 1'b1;
    #1;
    cmp("async_mem_req", 32'(mem_req), 32'd0);
    cmp("async_busy", 32'(busy), 32'd0);
    cmp("async_inst", inst, 32'd0);
    exp_busy = 1'b0; exp_mem_req = 1'b0; exp_inst = 32'd0;
    model_clear();
    tick();
    Rst = 1'b0;
    mem_ack = 1'b1; mem_data = {4{32'h5A5A_5A5A}};
    tick();
    mem_ack = 1'b0; mem_data = 128'd0;
    tick();
    fetch(32'h200, {32'h73, 32'h72, 32'h71, 32'h70}, 0, 1'b0, gh, gi, ga);
    cmp("post_reset_hit", 32'(gh), 32'd0);
    cmp("post_reset_inst", gi, 32'h70);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
